maxpool2x2_sa: RTL and testbench
================================

Name: maxpool2x2_sa

Overview:
- Downstream neighbour of the activation stage. Consumes its result stream (`act_*`) and performs 2x2, stride-2 max pooling over a row-major FMAP_W x FMAP_H feature map.
- Holds one row of partial maxima in an internal line buffer.
- Emits one pooled value per 2x2 window, with a 1-based sequential address and an end-of-frame last flag, toward the output buffer.
- There is no backpressure anywhere in the chain.

Parameters:
- DATA_W, 8: data width; sign-magnitude encoding (MSB = sign).
- ADDR_W, 10: address width of input and output.
- FMAP_W, 4: feature-map row length in elements; must be even and >= 2.
- FMAP_H, 4: feature-map row count; must be even and >= 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- act_valid_i  in  1  input element valid this cycle.
- act_result_i  in  DATA_W  activation result, sign-magnitude.
- act_result_address_i  in  ADDR_W  input address; not used for positioning, ignored.
- act_last_i  in  1  marks the final element of the frame; qualified by act_valid_i.
- pool_valid_o  out  1  pooled result valid, single-cycle pulse.
- pool_result_o  out  DATA_W  pooled maximum, sign-magnitude.
- pool_result_address_o  out  ADDR_W  1-based window index, row-major over the pooled map.
- pool_last_o  out  1  asserted with the final window of the frame.

Behaviour:
- Reset: all outputs 0. col_cnt, row_cnt, out_idx and the pair register clear; state = IDLE. Line buffer contents are don't-care and are never read before being written.
- Reset wins over a simultaneous act_valid_i. Reset mid-frame discards the partial frame with no output.
- Position comes only from internal counters. col_cnt covers 0..FMAP_W-1; row_cnt covers 0..FMAP_H-1. Both advance only on act_valid_i=1; cycles with valid low stall with state held and no output.
- Comparison max(a,b), sign-magnitude:
  - both non-negative: larger magnitude wins;
  - both negative: smaller magnitude wins;
  - mixed signs: the non-negative value wins;
  - +0 and -0 are equal; on a tie the result is a, the earlier-arriving operand.
- Even col: the element is latched into the pair register.
- Odd col: h = max(pair, element).
  - Even row: h is written to line_buf[col_cnt/2].
  - Odd row: the output is max(line_buf[col_cnt/2], h).
- Output timing: registered. pool_valid_o pulses the cycle after the odd-row/odd-col element is accepted (latency 1) and is 0 otherwise. Outputs hold their value while valid is 0.
- pool_result_address_o = out_idx + 1; out_idx increments per emitted window and wraps to 0 at end of frame.
- FSM:
  - IDLE -> RUN on the first accepted element.
  - RUN -> IDLE after the element at (FMAP_H-1, FMAP_W-1) is accepted. That element's window drives pool_last_o=1 with pool_valid_o.
  - Counters and out_idx then return to 0. A new frame may start on the very next cycle, including back-to-back with no idle cycle.
- act_last_i handling:
  - Asserted exactly at the final position: normal.
  - Asserted early (premature last): block aborts the frame, clears counters/out_idx and returns to IDLE, with no output for the incomplete window.
  - Final position reached without act_last_i: the frame still completes and pool_last_o is still asserted.
- Line-buffer read and write to the same index never occur in the same cycle: writes happen only on even rows, reads only on odd rows.

Optional Feature:
- Macro MAXPOOL_ERR_EN.
- Defined:
  - adds output port err_o (1 bit), reset 0;
  - err_o sets sticky on a premature act_last_i, or on act_last_i missing at the final position;
  - err_o clears only on rst.
- Undefined:
  - err_o port absent; frame-abort and completion behaviour are identical.

Test Plan:
- Frame 4x4, row-major input 1 2 3 4 / 0 0 0 0 / 9 10 11 12 / 0 0 0 0, act_valid_i continuous, act_last_i on the 16th element -> pool outputs (2,addr1), (4,addr2), (10,addr3), (12,addr4). Each output appears 1 cycle after its window's final element; pool_last_o=1 only with addr4.
- Sign-magnitude inputs -5 -6 -7 -8 / -1 -9 +0 -0 (8'h85 8'h86 8'h87 8'h88 / 8'h81 8'h89 8'h00 8'h80), FMAP_H=2 -> outputs 8'h81 (-1) and 8'h00 (+0 wins the tie as the earlier operand).
- Same 4x4 frame as test 1 with act_valid_i low for 3 cycles after every 5th element -> identical values and addresses, each delayed by the inserted gaps; no spurious pool_valid_o.
- Two back-to-back frames, with the second frame's first element in the cycle right after the first frame's last -> second frame addresses restart at 1, values correct, pool_last_o once per frame.
- rst asserted after 6 elements, then a full 4x4 frame -> no output from the partial frame; the new frame outputs addr1..4 correctly; all outputs 0 during and after reset.
- act_last_i on element 10 of a 4x4 frame, then a full frame -> aborted frame emits only addr1..2. The next frame starts at addr1. With MAXPOOL_ERR_EN, err_o=1 from the cycle after element 10 until rst.

Source files
------------

// File: rtl/maxpool2x2_sa_if.sv
// Stream bundle between the activation stage, the 2x2 max-pool block and the output buffer.
// master: upstream/testbench side; slave: the pooling block.
interface maxpool2x2_sa_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    logic              act_valid_i;
    logic [DATA_W-1:0] act_result_i;
    logic [ADDR_W-1:0] act_result_address_i;
    logic              act_last_i;

    logic              pool_valid_o;
    logic [DATA_W-1:0] pool_result_o;
    logic [ADDR_W-1:0] pool_result_address_o;
    logic              pool_last_o;

    modport master (
        output act_valid_i, act_result_i, act_result_address_i, act_last_i,
        input  pool_valid_o, pool_result_o, pool_result_address_o, pool_last_o
    );

    modport slave (
        input  act_valid_i, act_result_i, act_result_address_i, act_last_i,
        output pool_valid_o, pool_result_o, pool_result_address_o, pool_last_o
    );
endinterface

// File: rtl/maxpool2x2_sa.sv
// 2x2 stride-2 max pooling over a row-major sign-magnitude feature map, one line buffer of partial maxima.
// Optional sticky frame-error flag err_o when MAXPOOL_ERR_EN is defined.
//
// state | meaning
// IDLE  | no frame in progress, counters at 0
// RUN   | frame in progress
module maxpool2x2_sa #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int FMAP_W = 4,
    parameter int FMAP_H = 4
) (
    input  logic           clk,
    input  logic           rst,
    maxpool2x2_sa_if.slave p
`ifdef MAXPOOL_ERR_EN
    ,
    output logic           err_o
`endif
);

    localparam int CW = $clog2(FMAP_W);
    localparam int RW = $clog2(FMAP_H);
    localparam int LD = FMAP_W / 2;
    localparam int LW = (LD > 1) ? $clog2(LD) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(FMAP_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FMAP_H - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [ADDR_W-1:0] out_idx_q, out_idx_d;
    logic [DATA_W-1:0] pair_q, pair_d;
    logic [DATA_W-1:0] line_buf_q [LD];

    logic              pool_valid_q;
    logic [DATA_W-1:0] pool_result_q;
    logic [ADDR_W-1:0] pool_addr_q;
    logic              pool_last_q;

    logic [LW-1:0]     lb_idx;
    logic [DATA_W-1:0] h_max, win_max;
    logic              final_pos, premature;
    logic              emit, emit_last, lb_we;
    logic              unused_addr;

    assign unused_addr = ^p.act_result_address_i;

    // -0 is treated as non-negative so that +0/-0 compare equal and the tie keeps a.
    function automatic logic [DATA_W-1:0] sm_max(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic a_neg, b_neg, b_wins;
        a_neg = a[DATA_W-1] && (a[DATA_W-2:0] != '0);
        b_neg = b[DATA_W-1] && (b[DATA_W-2:0] != '0);
        if (a_neg != b_neg)
            b_wins = a_neg;
        else if (!a_neg)
            b_wins = b[DATA_W-2:0] > a[DATA_W-2:0];
        else
            b_wins = b[DATA_W-2:0] < a[DATA_W-2:0];
        return b_wins ? b : a;
    endfunction

    assign lb_idx    = LW'(col_q >> 1);
    assign h_max     = sm_max(pair_q, p.act_result_i);
    assign win_max   = sm_max(line_buf_q[lb_idx], h_max);
    assign final_pos = (col_q == COL_LAST) && (row_q == ROW_LAST);
    assign premature = p.act_last_i && !final_pos;

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        out_idx_d = out_idx_q;
        pair_d    = pair_q;
        emit      = 1'b0;
        emit_last = 1'b0;
        lb_we     = 1'b0;
        if (p.act_valid_i) begin
            if (state_q == IDLE)
                state_d = RUN;
            if (premature) begin
                state_d   = IDLE;
                col_d     = '0;
                row_d     = '0;
                out_idx_d = '0;
            end else begin
                if (!col_q[0])
                    pair_d = p.act_result_i;
                else if (!row_q[0])
                    lb_we = 1'b1;
                else begin
                    emit      = 1'b1;
                    out_idx_d = out_idx_q + ADDR_W'(1);
                end
                if (final_pos) begin
                    state_d   = IDLE;
                    col_d     = '0;
                    row_d     = '0;
                    out_idx_d = '0;
                    emit_last = 1'b1;
                end else if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            col_q         <= '0;
            row_q         <= '0;
            out_idx_q     <= '0;
            pair_q        <= '0;
            pool_valid_q  <= 1'b0;
            pool_result_q <= '0;
            pool_addr_q   <= '0;
            pool_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            out_idx_q    <= out_idx_d;
            pair_q       <= pair_d;
            pool_valid_q <= emit;
            if (emit) begin
                pool_result_q <= win_max;
                pool_addr_q   <= out_idx_q + ADDR_W'(1);
                pool_last_q   <= emit_last;
            end
        end
    end

    // Contents need no reset: odd rows only read entries written on the preceding even row.
    always_ff @(posedge clk) begin
        if (lb_we && !rst)
            line_buf_q[lb_idx] <= h_max;
    end

    assign p.pool_valid_o          = pool_valid_q;
    assign p.pool_result_o         = pool_result_q;
    assign p.pool_result_address_o = pool_addr_q;
    assign p.pool_last_o           = pool_last_q;

`ifdef MAXPOOL_ERR_EN
    logic err_q;
    logic err_set;

    assign err_set = p.act_valid_i && (premature || (final_pos && !p.act_last_i));

    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else if (err_set)
            err_q <= 1'b1;
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_maxpool2x2_sa.sv
// Directed self-checking bench for maxpool2x2_sa: a 4x4 instance for framing tests and a 4x2 instance for sign-magnitude ordering.
module tb_maxpool2x2_sa;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    maxpool2x2_sa_if #(.DATA_W(8), .ADDR_W(10)) if0 ();
    maxpool2x2_sa_if #(.DATA_W(8), .ADDR_W(10)) if1 ();

`ifdef MAXPOOL_ERR_EN
    logic err0, err1;
`endif

    maxpool2x2_sa #(.DATA_W(8), .ADDR_W(10), .FMAP_W(4), .FMAP_H(4)) dut0 (
        .clk(clk), .rst(rst), .p(if0.slave)
`ifdef MAXPOOL_ERR_EN
        , .err_o(err0)
`endif
    );

    maxpool2x2_sa #(.DATA_W(8), .ADDR_W(10), .FMAP_W(4), .FMAP_H(2)) dut1 (
        .clk(clk), .rst(rst), .p(if1.slave)
`ifdef MAXPOOL_ERR_EN
        , .err_o(err1)
`endif
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int chk_cnt = 0;
    int pass_cnt = 0;
    int last_in;
    int in_cyc[32];

    logic [7:0] fr[16] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0,
                           8'd9, 8'd10, 8'd11, 8'd12, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [7:0] ev[4]  = '{8'd2, 8'd4, 8'd10, 8'd12};
    int         ce[4]  = '{5, 7, 13, 15};

    logic [7:0] m0_val[64];
    logic [9:0] m0_addr[64];
    logic       m0_last[64];
    int         m0_cyc[64];
    int         m0_n = 0;
    logic [7:0] m1_val[64];
    logic [9:0] m1_addr[64];
    logic       m1_last[64];
    int         m1_cyc[64];
    int         m1_n = 0;

    always @(negedge clk) begin
        if (if0.pool_valid_o === 1'b1) begin
            if (m0_n < 64) begin
                m0_val[m0_n]  = if0.pool_result_o;
                m0_addr[m0_n] = if0.pool_result_address_o;
                m0_last[m0_n] = if0.pool_last_o;
                m0_cyc[m0_n]  = cyc;
            end
            m0_n = m0_n + 1;
        end
        if (if1.pool_valid_o === 1'b1) begin
            if (m1_n < 64) begin
                m1_val[m1_n]  = if1.pool_result_o;
                m1_addr[m1_n] = if1.pool_result_address_o;
                m1_last[m1_n] = if1.pool_last_o;
                m1_cyc[m1_n]  = cyc;
            end
            m1_n = m1_n + 1;
        end
    end

    task automatic drive0(input logic v, input logic [7:0] d, input logic l);
        @(negedge clk);
        if0.act_valid_i          = v;
        if0.act_result_i         = d;
        if0.act_last_i           = l;
        if0.act_result_address_i = 10'(cyc);
        last_in                  = cyc;
    endtask

    task automatic drive1(input logic v, input logic [7:0] d, input logic l);
        @(negedge clk);
        if1.act_valid_i          = v;
        if1.act_result_i         = d;
        if1.act_last_i           = l;
        if1.act_result_address_i = 10'(cyc);
        last_in                  = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) drive0(1'b0, 8'h0, 1'b0);
        chk_cnt++;
        if (if0.pool_valid_o !== 1'b0) $display("FAIL reset valid: got %b expected 0", if0.pool_valid_o);
        else pass_cnt++;
        chk_cnt++;
        if (if0.pool_result_o !== 8'h0) $display("FAIL reset result: got %h expected 00", if0.pool_result_o);
        else pass_cnt++;
        chk_cnt++;
        if (if0.pool_result_address_o !== 10'h0) $display("FAIL reset addr: got %0d expected 0", if0.pool_result_address_o);
        else pass_cnt++;
        chk_cnt++;
        if (if0.pool_last_o !== 1'b0) $display("FAIL reset last: got %b expected 0", if0.pool_last_o);
        else pass_cnt++;
        chk_cnt++;
        if (if1.pool_valid_o !== 1'b0) $display("FAIL reset valid1: got %b expected 0", if1.pool_valid_o);
        else pass_cnt++;
`ifdef MAXPOOL_ERR_EN
        chk_cnt++;
        if (err0 !== 1'b0 || err1 !== 1'b0) $display("FAIL reset err: got %b%b expected 00", err0, err1);
        else pass_cnt++;
`endif
        @(negedge clk);
        rst = 1'b0;
        drive0(1'b0, 8'h0, 1'b0);
    endtask

    task automatic test_basic();
        int base;
        base = m0_n;
        for (int i = 0; i < 16; i++) begin
            drive0(1'b1, fr[i], i == 15);
            in_cyc[i] = last_in;
        end
        repeat (3) drive0(1'b0, 8'h0, 1'b0);
        chk_cnt++;
        if (m0_n - base !== 4) $display("FAIL basic count: got %0d expected 4", m0_n - base);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            chk_cnt++;
            if (m0_val[base+k] !== ev[k]) $display("FAIL basic val[%0d]: got %0d expected %0d", k, m0_val[base+k], ev[k]);
            else pass_cnt++;
            chk_cnt++;
            if (m0_addr[base+k] !== 10'(k + 1)) $display("FAIL basic addr[%0d]: got %0d expected %0d", k, m0_addr[base+k], k + 1);
            else pass_cnt++;
            chk_cnt++;
            if (m0_last[base+k] !== (k == 3)) $display("FAIL basic last[%0d]: got %b expected %b", k, m0_last[base+k], k == 3);
            else pass_cnt++;
            chk_cnt++;
            if (m0_cyc[base+k] !== in_cyc[ce[k]] + 1) $display("FAIL basic latency[%0d]: got cycle %0d expected %0d", k, m0_cyc[base+k], in_cyc[ce[k]] + 1);
            else pass_cnt++;
        end
    endtask

    task automatic test_sign();
        int base;
        logic [7:0] sv[8];
        logic [7:0] sexp[2];
        sv   = '{8'h85, 8'h86, 8'h87, 8'h88, 8'h81, 8'h89, 8'h00, 8'h80};
        sexp = '{8'h81, 8'h00};
        base = m1_n;
        for (int i = 0; i < 8; i++) begin
            drive1(1'b1, sv[i], i == 7);
            in_cyc[i] = last_in;
        end
        repeat (3) drive1(1'b0, 8'h0, 1'b0);
        chk_cnt++;
        if (m1_n - base !== 2) $display("FAIL sign count: got %0d expected 2", m1_n - base);
        else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            chk_cnt++;
            if (m1_val[base+k] !== sexp[k]) $display("FAIL sign val[%0d]: got %h expected %h", k, m1_val[base+k], sexp[k]);
            else pass_cnt++;
            chk_cnt++;
            if (m1_addr[base+k] !== 10'(k + 1)) $display("FAIL sign addr[%0d]: got %0d expected %0d", k, m1_addr[base+k], k + 1);
            else pass_cnt++;
            chk_cnt++;
            if (m1_last[base+k] !== (k == 1)) $display("FAIL sign last[%0d]: got %b expected %b", k, m1_last[base+k], k == 1);
            else pass_cnt++;
            chk_cnt++;
            if (m1_cyc[base+k] !== in_cyc[5 + 2*k] + 1) $display("FAIL sign latency[%0d]: got cycle %0d expected %0d", k, m1_cyc[base+k], in_cyc[5 + 2*k] + 1);
            else pass_cnt++;
        end
    endtask

    task automatic test_gaps();
        int base;
        base = m0_n;
        for (int i = 0; i < 16; i++) begin
            drive0(1'b1, fr[i], i == 15);
            in_cyc[i] = last_in;
            if ((i + 1) % 5 == 0) repeat (3) drive0(1'b0, 8'hEE, 1'b0);
        end
        repeat (3) drive0(1'b0, 8'h0, 1'b0);
        chk_cnt++;
        if (m0_n - base !== 4) $display("FAIL gaps count: got %0d expected 4", m0_n - base);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            chk_cnt++;
            if (m0_val[base+k] !== ev[k]) $display("FAIL gaps val[%0d]: got %0d expected %0d", k, m0_val[base+k], ev[k]);
            else pass_cnt++;
            chk_cnt++;
            if (m0_addr[base+k] !== 10'(k + 1)) $display("FAIL gaps addr[%0d]: got %0d expected %0d", k, m0_addr[base+k], k + 1);
            else pass_cnt++;
            chk_cnt++;
            if (m0_cyc[base+k] !== in_cyc[ce[k]] + 1) $display("FAIL gaps latency[%0d]: got cycle %0d expected %0d", k, m0_cyc[base+k], in_cyc[ce[k]] + 1);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int base;
        int ci;
        base = m0_n;
        for (int i = 0; i < 32; i++) begin
            drive0(1'b1, fr[i%16], (i % 16) == 15);
            in_cyc[i] = last_in;
        end
        repeat (3) drive0(1'b0, 8'h0, 1'b0);
        chk_cnt++;
        if (m0_n - base !== 8) $display("FAIL b2b count: got %0d expected 8", m0_n - base);
        else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            ci = (k / 4) * 16 + ce[k%4];
            chk_cnt++;
            if (m0_val[base+k] !== ev[k%4]) $display("FAIL b2b val[%0d]: got %0d expected %0d", k, m0_val[base+k], ev[k%4]);
            else pass_cnt++;
            chk_cnt++;
            if (m0_addr[base+k] !== 10'(k % 4 + 1)) $display("FAIL b2b addr[%0d]: got %0d expected %0d", k, m0_addr[base+k], k % 4 + 1);
            else pass_cnt++;
            chk_cnt++;
            if (m0_last[base+k] !== (k % 4 == 3)) $display("FAIL b2b last[%0d]: got %b expected %b", k, m0_last[base+k], k % 4 == 3);
            else pass_cnt++;
            chk_cnt++;
            if (m0_cyc[base+k] !== in_cyc[ci] + 1) $display("FAIL b2b latency[%0d]: got cycle %0d expected %0d", k, m0_cyc[base+k], in_cyc[ci] + 1);
            else pass_cnt++;
        end
    endtask

    task automatic test_rst_mid();
        int base;
        base = m0_n;
        for (int i = 0; i < 5; i++) drive0(1'b1, fr[i], 1'b0);
        @(negedge clk);
        rst = 1'b1;
        if0.act_valid_i  = 1'b1;
        if0.act_result_i = fr[5];
        if0.act_last_i   = 1'b0;
        drive0(1'b0, 8'h0, 1'b0);
        chk_cnt++;
        if ({if0.pool_valid_o, if0.pool_result_o, if0.pool_result_address_o, if0.pool_last_o} !== 20'h0)
            $display("FAIL rst_mid during: got v=%b r=%h a=%0d l=%b expected all 0", if0.pool_valid_o, if0.pool_result_o, if0.pool_result_address_o, if0.pool_last_o);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        drive0(1'b0, 8'h0, 1'b0);
        chk_cnt++;
        if ({if0.pool_valid_o, if0.pool_result_o, if0.pool_result_address_o, if0.pool_last_o} !== 20'h0)
            $display("FAIL rst_mid after: got v=%b r=%h a=%0d l=%b expected all 0", if0.pool_valid_o, if0.pool_result_o, if0.pool_result_address_o, if0.pool_last_o);
        else pass_cnt++;
        chk_cnt++;
        if (m0_n - base !== 0) $display("FAIL rst_mid partial: got %0d outputs expected 0", m0_n - base);
        else pass_cnt++;
        base = m0_n;
        for (int i = 0; i < 16; i++) drive0(1'b1, fr[i], i == 15);
        repeat (3) drive0(1'b0, 8'h0, 1'b0);
        chk_cnt++;
        if (m0_n - base !== 4) $display("FAIL rst_mid count: got %0d expected 4", m0_n - base);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            chk_cnt++;
            if (m0_val[base+k] !== ev[k] || m0_addr[base+k] !== 10'(k + 1))
                $display("FAIL rst_mid out[%0d]: got %0d@%0d expected %0d@%0d", k, m0_val[base+k], m0_addr[base+k], ev[k], k + 1);
            else pass_cnt++;
        end
    endtask

    task automatic test_premature();
        int base;
        base = m0_n;
        for (int i = 0; i < 10; i++) begin
`ifdef MAXPOOL_ERR_EN
            if (i == 9) begin
                chk_cnt++;
                if (err0 !== 1'b0) $display("FAIL premature err_before: got %b expected 0", err0);
                else pass_cnt++;
            end
`endif
            drive0(1'b1, fr[i], i == 9);
        end
        drive0(1'b0, 8'h0, 1'b0);
`ifdef MAXPOOL_ERR_EN
        chk_cnt++;
        if (err0 !== 1'b1) $display("FAIL premature err_after: got %b expected 1", err0);
        else pass_cnt++;
`endif
        repeat (2) drive0(1'b0, 8'h0, 1'b0);
        chk_cnt++;
        if (m0_n - base !== 2) $display("FAIL premature count: got %0d expected 2", m0_n - base);
        else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            chk_cnt++;
            if (m0_val[base+k] !== ev[k] || m0_addr[base+k] !== 10'(k + 1) || m0_last[base+k] !== 1'b0)
                $display("FAIL premature out[%0d]: got %0d@%0d last %b expected %0d@%0d last 0", k, m0_val[base+k], m0_addr[base+k], m0_last[base+k], ev[k], k + 1);
            else pass_cnt++;
        end
        base = m0_n;
        for (int i = 0; i < 16; i++) drive0(1'b1, fr[i], i == 15);
        repeat (3) drive0(1'b0, 8'h0, 1'b0);
        chk_cnt++;
        if (m0_n - base !== 4) $display("FAIL premature next count: got %0d expected 4", m0_n - base);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            chk_cnt++;
            if (m0_val[base+k] !== ev[k] || m0_addr[base+k] !== 10'(k + 1) || m0_last[base+k] !== (k == 3))
                $display("FAIL premature next out[%0d]: got %0d@%0d last %b expected %0d@%0d last %b", k, m0_val[base+k], m0_addr[base+k], m0_last[base+k], ev[k], k + 1, k == 3);
            else pass_cnt++;
        end
`ifdef MAXPOOL_ERR_EN
        chk_cnt++;
        if (err0 !== 1'b1) $display("FAIL premature err_sticky: got %b expected 1", err0);
        else pass_cnt++;
`endif
    endtask

    task automatic test_missing_last();
        int base;
        base = m0_n;
        for (int i = 0; i < 16; i++) drive0(1'b1, fr[i], 1'b0);
        repeat (3) drive0(1'b0, 8'h0, 1'b0);
        chk_cnt++;
        if (m0_n - base !== 4) $display("FAIL nolast count: got %0d expected 4", m0_n - base);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            chk_cnt++;
            if (m0_val[base+k] !== ev[k] || m0_addr[base+k] !== 10'(k + 1) || m0_last[base+k] !== (k == 3))
                $display("FAIL nolast out[%0d]: got %0d@%0d last %b expected %0d@%0d last %b", k, m0_val[base+k], m0_addr[base+k], m0_last[base+k], ev[k], k + 1, k == 3);
            else pass_cnt++;
        end
`ifdef MAXPOOL_ERR_EN
        chk_cnt++;
        if (err0 !== 1'b1) $display("FAIL nolast err: got %b expected 1", err0);
        else pass_cnt++;
`endif
    endtask

    initial begin
        if0.act_valid_i = 1'b0; if0.act_result_i = '0; if0.act_result_address_i = '0; if0.act_last_i = 1'b0;
        if1.act_valid_i = 1'b0; if1.act_result_i = '0; if1.act_result_address_i = '0; if1.act_last_i = 1'b0;
        test_reset();
        test_basic();
        test_sign();
        test_gaps();
        test_back_to_back();
        test_rst_mid();
        test_premature();
        test_missing_last();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
